// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel, W-bit round-robin arbitrating mux with valid/ready
// on every input and one registered output stage.
// Optional build macro RR_ARB_MUX_FIXED_PRIO_EN: removes the round-robin
// pointer so the lowest-index valid channel always wins.
module rr_arb_mux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [SELW-1:0]  ch_q;
  logic [SELW-1:0]  ptr_q;

  logic             free;
  logic             gnt_any;
  logic [SELW-1:0]  gnt_ch;
  logic [SELW:0]    idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer_in;

  // Output stage can take a word when empty or when its word leaves this edge.
  assign free = !valid_q || out_ready;

  // Find the first valid channel scanning ptr, ptr+1, ... with wrap at NCH.
  // One extra index bit lets the wrap be a single subtract, so non-power-of-two
  // NCH never produces an index >= NCH.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = {1'b0, ptr_q} + (SELW+1)'(i);
      if (idx >= (SELW+1)'(NCH)) idx = idx - (SELW+1)'(NCH);
      if (!gnt_any && in_valid[idx[SELW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_ch  = idx[SELW-1:0];
      end
    end
  end

  assign xfer_in  = free && gnt_any;
  assign gnt_data = in_data[int'(gnt_ch)*WIDTH +: WIDTH];

  // One-hot ready to the winner; forced low while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && xfer_in) in_ready[gnt_ch] = 1'b1;
  end

  // Output register: load on input transfer, drain on output transfer, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else if (xfer_in) begin
      valid_q <= 1'b1;
      data_q  <= gnt_data;
      ch_q    <= gnt_ch;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [SELW-1:0] ptr_d;
  assign ptr_d = (gnt_ch == SELW'(NCH-1)) ? '0 : gnt_ch + SELW'(1);

  // Round-robin pointer moves just past the winner, only on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= '0;
    else if (xfer_in) ptr_q <= ptr_d;
  end
`endif

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a spec-level model compared every negedge plus
// directed vectors with literal expectations (NCH=4 and NCH=3 instances).
module tb_rr_arb_mux;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int N3 = 3;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;
  logic [1:0]     out_ch;

  logic [N3*W-1:0] d3;
  logic [N3-1:0]   v3, r3;
  logic [W-1:0]    od3;
  logic            ov3, or3;
  logic [1:0]      oc3;

  rr_arb_mux #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch));

  rr_arb_mux #(.WIDTH(W), .NCH(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
    .in_ready(r3), .out_data(od3), .out_valid(ov3),
    .out_ready(or3), .out_ch(oc3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: first valid channel scanning from p with wrap; -1 if none.
  function automatic int pick(input int p, input logic [N-1:0] v);
    int s;
    s = FIXED ? 0 : p;
    for (int k = 0; k < N; k++)
      if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  // Behavioural model of the NCH=4 instance.
  bit         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_ch = 0;
  int         m_ptr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    end else begin
      int g;
      g = (!m_valid || out_ready) ? pick(m_ptr, in_valid) : -1;
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_ch    = g;
        m_ptr   = (g + 1) % N;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] er;
    int g;
    er = '0;
    if (rst_n && (!m_valid || out_ready)) begin
      g = pick(m_ptr, in_valid);
      if (g >= 0) er[g] = 1'b1;
    end
    chk("model_in_ready", in_ready, er);
    chk("model_out_valid", out_valid, m_valid);
    chk("model_out_data", out_data, m_data);
    chk("model_out_ch", out_ch, m_ch);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = '0; out_ready = 1'b0;
    d3 = {8'hC3, 8'hB2, 8'hA1}; v3 = '0; or3 = 1'b1;

    // Reset and idle after release.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_ch", out_ch, 2'd0);
      chk("rst_in_ready", in_ready, 4'b0000);
    end

    // All valid, out_ready=1: rotate 0,1,2,3 then wrap to 0.
    @(posedge clk); #1;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk("rr_out_ch", out_ch, FIXED ? 0 : k % 4);
      chk("rr_out_data", out_data, FIXED ? 8'h11 : 8'h11 * ((k % 4) + 1));
      chk("rr_out_valid", out_valid, 1'b1);
    end

    // Async reset while holding a word: out_valid drops without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_in_ready", in_ready, 4'b0000);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ch", out_ch, 2'd0);
    chk("post_rst_data", out_data, 8'h11);

    // Stall three cycles: word held, nothing granted; then ch1 next.
    #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_data", out_data, 8'h11);
      chk("stall_ch", out_ch, 2'd0);
      chk("stall_in_ready", in_ready, 4'b0000);
    end
    #1 out_ready = 1'b1;
    #1 chk("unstall_in_ready", in_ready, FIXED ? 4'b0001 : 4'b0010);
    @(posedge clk); @(negedge clk);
    chk("unstall_ch", out_ch, FIXED ? 2'd0 : 2'd1);
    chk("unstall_data", out_data, FIXED ? 8'h11 : 8'h22);

    // Sparse valids: ch2 served, then from ptr=3 the search wraps to ch0.
    #1 in_valid = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("sparse_ch2", out_ch, 2'd2);
    chk("sparse_data2", out_data, 8'h33);
    #1 in_valid = 4'b0001;
    @(posedge clk); @(negedge clk);
    chk("wrap_ch0", out_ch, 2'd0);
    chk("wrap_data0", out_data, 8'h11);

    // Idle: output drains, ch held, ptr unchanged (next grant is ch1).
    #1 in_valid = 4'b0000;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_ch_hold", out_ch, 2'd0);
    end
    #1 in_valid = 4'b1111;
    @(posedge clk); @(negedge clk);
    chk("idle_ptr_ch", out_ch, FIXED ? 2'd0 : 2'd1);

    // Mixed valid / backpressure table, checked by the model.
    begin
      logic [4:0] vec [8];
      vec = '{5'b1010_1, 5'b1010_0, 5'b0110_1, 5'b1001_1,
              5'b0000_1, 5'b1000_0, 5'b1000_1, 5'b0011_1};
      for (int k = 0; k < 8; k++) begin
        #1 {in_valid, out_ready} = vec[k];
        @(posedge clk); @(negedge clk);
      end
    end
    #1 in_valid = '0; out_ready = 1'b1;

    // NCH=3 instance: 0,1,2,0,1 and never 3.
    v3 = 3'b111;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk("n3_ch", oc3, FIXED ? 0 : k % 3);
      chk("n3_data", od3, FIXED ? 8'hA1 : 8'hA1 + 8'h11 * (k % 3));
      chk("n3_range", oc3 < 2'd3, 1'b1);
    end
    #1 v3 = '0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
